vec_cache_evdb_slot_alloc: RTL

//  Allocates and recycles evict-data-buffer slots (4 beats each; db_entry_id = {slot, beat[1:0]}).

---
 rtl/vector_cache_pkg.sv | 19 +
 rtl/vec_cache_evdb_slot_pick.sv | 31 +++
 rtl/vec_cache_evdb_slot_alloc.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/vector_cache_pkg.sv
// Shared vector-cache definitions used by the EVDB slot allocator and its
// find-first-set helper.
//   evdb_slot_state_e  : per-slot life cycle (IDLE -> ALLOC -> FULL -> IDLE)
//   EVDB_SLOT_NUM      : number of 4-beat evict-data-buffer slots
//   EVDB_SLOT_ID_WIDTH : slot index width
//   EVDB_CNT_WIDTH     : width of a counter that can hold 0..EVDB_SLOT_NUM
package vector_cache_pkg;

    localparam int EVDB_SLOT_NUM      = 8;
    localparam int EVDB_SLOT_ID_WIDTH = $clog2(EVDB_SLOT_NUM);
    localparam int EVDB_CNT_WIDTH     = $clog2(EVDB_SLOT_NUM + 1);

    typedef enum logic [1:0] {
        EVDB_IDLE  = 2'd0,
        EVDB_ALLOC = 2'd1,
        EVDB_FULL  = 2'd2
    } evdb_slot_state_e;

endpackage : vector_cache_pkg

// File: rtl/vec_cache_evdb_slot_pick.sv
// Combinational lowest-index find-first-set over a candidate mask.
// Generic enough to be shared by the rob/mshr allocators.
// Ports:
//   mask : candidate bit per entry
//   vld  : at least one candidate bit is set
//   idx  : index of the lowest set bit (zero when vld is low)
module vec_cache_evdb_slot_pick #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     mask,
    output logic             vld,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        vld = 1'b0;
        idx = {IDX_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                vld = 1'b1;
                idx = IDX_W'(i);
            end else begin
                vld = vld;
                idx = idx;
            end
        end
    end

endmodule : vec_cache_evdb_slot_pick

// File: rtl/vec_cache_evdb_slot_alloc.sv
// Evict-data-buffer slot allocator. Owns occupancy of the 4-beat EVDB slots,
// offers a pre-selected free slot to the evict issue path, tracks each slot
// through fill and drain, and frees it on the last downstream beat.
// Optional feature macro: VEC_CACHE_EVDB_ALLOC_PEAK_EN (adds peak_cnt).
// Ports:
//   clk, rst_n                     : clock, synchronous active-low reset
//   alloc_vld/alloc_rdy/alloc_slot : free-slot offer and handshake
//   fill_done_vld/fill_done_slot   : last beat of a slot written
//   release_vld/release_slot       : last downstream beat accepted
//   free_cnt                       : number of IDLE slots (registered)
//   err_vld/err_code               : sticky protocol error
//                                    (bit0 bad fill, bit1 bad release)
//   peak_cnt                       : max occupancy since reset (macro only)
module vec_cache_evdb_slot_alloc
    import vector_cache_pkg::*;
#(
    parameter int SLOT_NUM      = EVDB_SLOT_NUM,
    parameter int SLOT_ID_WIDTH = $clog2(SLOT_NUM),
    parameter int CNT_WIDTH     = $clog2(SLOT_NUM + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     alloc_vld,
    input  logic                     alloc_rdy,
    output logic [SLOT_ID_WIDTH-1:0] alloc_slot,
    input  logic                     fill_done_vld,
    input  logic [SLOT_ID_WIDTH-1:0] fill_done_slot,
    input  logic                     release_vld,
    input  logic [SLOT_ID_WIDTH-1:0] release_slot,
    output logic [CNT_WIDTH-1:0]     free_cnt,
    output logic                     err_vld,
    output logic [1:0]               err_code
`ifdef VEC_CACHE_EVDB_ALLOC_PEAK_EN
    ,
    output logic [CNT_WIDTH-1:0]     peak_cnt
`endif
);

    evdb_slot_state_e           state_r     [SLOT_NUM];
    evdb_slot_state_e           state_nxt_s [SLOT_NUM];
    logic [SLOT_NUM-1:0]        cand_s;
    logic                       pick_vld_s;
    logic [SLOT_ID_WIDTH-1:0]   pick_idx_s;

    logic                       alloc_vld_r;
    logic [SLOT_ID_WIDTH-1:0]   alloc_slot_r;
    logic [CNT_WIDTH-1:0]       free_cnt_r;
    logic [CNT_WIDTH-1:0]       free_cnt_nxt_s;
    logic [1:0]                 err_code_r;
    logic [1:0]                 err_code_nxt_s;

    logic                       grant_s;
    logic                       fill_ok_s;
    logic                       fill_err_s;
    logic                       rel_same_s;
    logic                       rel_ok_s;
    logic                       rel_err_s;

    // Classify this cycle's grant, fill and release events as legal or not.
    always_comb begin
        grant_s    = alloc_vld_r && alloc_rdy;
        fill_ok_s  = fill_done_vld && (state_r[fill_done_slot] == EVDB_ALLOC);
        fill_err_s = fill_done_vld && !fill_ok_s;
        // A release colliding with a fill on the same slot is dropped and
        // reported; the fill wins.
        rel_same_s = release_vld && fill_done_vld && (release_slot == fill_done_slot);
        rel_ok_s   = release_vld && !rel_same_s && (state_r[release_slot] == EVDB_FULL);
        rel_err_s  = release_vld && !rel_ok_s;
    end

    // Per-slot next state and the candidate mask for the next offer.
    always_comb begin
        for (int i = 0; i < SLOT_NUM; i++) begin
            state_nxt_s[i] = state_r[i];
            case (state_r[i])
                EVDB_IDLE: begin
                    if (grant_s && (alloc_slot_r == SLOT_ID_WIDTH'(i))) begin
                        state_nxt_s[i] = EVDB_ALLOC;
                    end else begin
                        state_nxt_s[i] = EVDB_IDLE;
                    end
                end
                EVDB_ALLOC: begin
                    if (fill_ok_s && (fill_done_slot == SLOT_ID_WIDTH'(i))) begin
                        state_nxt_s[i] = EVDB_FULL;
                    end else begin
                        state_nxt_s[i] = EVDB_ALLOC;
                    end
                end
                EVDB_FULL: begin
                    if (rel_ok_s && (release_slot == SLOT_ID_WIDTH'(i))) begin
                        state_nxt_s[i] = EVDB_IDLE;
                    end else begin
                        state_nxt_s[i] = EVDB_FULL;
                    end
                end
                default: begin
                    state_nxt_s[i] = EVDB_IDLE;
                end
            endcase
            // Candidates are judged on the current state, so a slot released
            // this cycle becomes offerable one edge later at the earliest.
            cand_s[i] = (state_r[i] == EVDB_IDLE)
                     && !(grant_s && (alloc_slot_r == SLOT_ID_WIDTH'(i)))
                     && !(release_vld && (release_slot == SLOT_ID_WIDTH'(i)));
        end
    end

    // Occupancy and sticky error bits for the coming edge.
    always_comb begin
        free_cnt_nxt_s = free_cnt_r
                       - {{(CNT_WIDTH-1){1'b0}}, grant_s}
                       + {{(CNT_WIDTH-1){1'b0}}, rel_ok_s};
        err_code_nxt_s = err_code_r | {rel_err_s, fill_err_s};
    end

    vec_cache_evdb_slot_pick #(
        .N     (SLOT_NUM),
        .IDX_W (SLOT_ID_WIDTH)
    ) u_pick (
        .mask (cand_s),
        .vld  (pick_vld_s),
        .idx  (pick_idx_s)
    );

    // Slot state array.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOT_NUM; i++) begin
                state_r[i] <= EVDB_IDLE;
            end
        end else begin
            for (int i = 0; i < SLOT_NUM; i++) begin
                state_r[i] <= state_nxt_s[i];
            end
        end
    end

    // Pre-alloc register: an offer is held until taken, reloaded otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alloc_vld_r  <= 1'b0;
            alloc_slot_r <= {SLOT_ID_WIDTH{1'b0}};
        end else if (grant_s || !alloc_vld_r) begin
            alloc_vld_r  <= pick_vld_s;
            alloc_slot_r <= pick_idx_s;
        end else begin
            alloc_vld_r  <= alloc_vld_r;
            alloc_slot_r <= alloc_slot_r;
        end
    end

    // Free counter and sticky error register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            free_cnt_r <= CNT_WIDTH'(SLOT_NUM);
            err_code_r <= 2'b00;
        end else begin
            free_cnt_r <= free_cnt_nxt_s;
            err_code_r <= err_code_nxt_s;
        end
    end

    assign alloc_vld  = alloc_vld_r;
    assign alloc_slot = alloc_slot_r;
    assign free_cnt   = free_cnt_r;
    assign err_code   = err_code_r;
    assign err_vld    = |err_code_r;

`ifdef VEC_CACHE_EVDB_ALLOC_PEAK_EN
    logic [CNT_WIDTH-1:0] peak_r;
    logic [CNT_WIDTH-1:0] occ_nxt_s;

    // Occupancy after this edge, the value the peak tracks.
    always_comb begin
        occ_nxt_s = CNT_WIDTH'(SLOT_NUM) - free_cnt_nxt_s;
    end

    // High-water mark of occupancy since reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak_r <= {CNT_WIDTH{1'b0}};
        end else if (occ_nxt_s > peak_r) begin
            peak_r <= occ_nxt_s;
        end else begin
            peak_r <= peak_r;
        end
    end

    assign peak_cnt = peak_r;
`endif

endmodule : vec_cache_evdb_slot_alloc
